ioctl_wb_loader: RTL and testbench

Parametrised bridge between the HPS ioctl download port and the single Wishbone RAM port of the core. It buffers downloaded words in a small FIFO, throttles the HPS with `ioctl_wait`, and issues Wishbone write cycles to SDRAM. It also owns arbitration of the RAM port between the loader and the CPU-side master. It succeeds the fixed 32-bit, single-register loader mux in the top level, adding:

- configurable width, depth and base address
- safe hand-off from an in-flight core cycle
- post-download FIFO flush
- overflow and progress reporting

---
 rtl/archie_loader_pkg.sv | 27 ++
 rtl/ioctl_wb_loader_if.sv | 18 +
 rtl/ioctl_wb_loader_fifo.sv | 49 ++++
 rtl/ioctl_wb_loader.sv | 168 ++++++++++++++++
 tb/tb_ioctl_wb_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/archie_loader_pkg.sv
// Shared types and helpers for the ioctl download loader.
// fifo_entry_t describes the default 32-bit / 24-bit RAM build.
package archie_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDOFF = 2'd1,
    ST_LOAD    = 2'd2,
    ST_FLUSH   = 2'd3
  } ldr_state_t;

  localparam int unsigned LDR_DW  = 32;
  localparam int unsigned LDR_RAW = 24;
  localparam int unsigned LDR_SW  = LDR_DW / 8;

  typedef struct packed {
    logic [LDR_RAW-1:0] adr;
    logic [LDR_DW-1:0]  dat;
    logic [LDR_SW-1:0]  sel;
  } fifo_entry_t;

  // Clears the byte-lane bits of a byte address; sw must be a power of 2.
  function automatic logic [31:0] word_align(input logic [31:0] adr, input int unsigned sw);
    return adr & ~(sw - 32'd1);
  endfunction

endpackage

// File: rtl/ioctl_wb_loader_if.sv
// Wishbone write-capable bus bundle used on both the core side and the RAM side.
interface ioctl_wb_loader_if #(
  parameter int DW  = 32,
  parameter int RAW = 24
);
  localparam int SW = DW / 8;

  logic           stb;
  logic           cyc;
  logic           we;
  logic [SW-1:0]  sel;
  logic [RAW-1:0] adr;
  logic [DW-1:0]  dat;
  logic           ack;

  modport master (output stb, output cyc, output we, output sel, output adr, output dat, input ack);
  modport slave  (input stb, input cyc, input we, input sel, input adr, input dat, output ack);
endinterface

// File: rtl/ioctl_wb_loader_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module ldr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/ioctl_wb_loader.sv
// Bridges the HPS ioctl download port onto the shared Wishbone RAM port,
// owning arbitration between the loader FIFO and the core master.
module ioctl_wb_loader
  import archie_loader_pkg::*;
#(
  parameter int             DW    = 32,
  parameter int             AW    = 25,
  parameter int             RAW   = 24,
  parameter int             DEPTH = 4,
  parameter logic [RAW-1:0] BASE  = '0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [AW-1:0]        ioctl_addr,
  input  logic [DW-1:0]        ioctl_dout,
  input  logic [DW/8-1:0]      ioctl_sel,
  output logic                 ioctl_wait,
  ioctl_wb_loader_if.slave     core,
  ioctl_wb_loader_if.master    ram,
  output logic                 busy,
  output logic                 overflow,
  output logic [23:0]          words
);
  localparam int SW = DW / 8;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [RAW-1:0] adr;
    logic [DW-1:0]  dat;
    logic [SW-1:0]  sel;
  } entry_t;

  // state      | meaning
  // ST_IDLE    | core owns RAM port, combinational passthrough
  // ST_HANDOFF | download started, waiting for core cycle in flight to finish
  // ST_LOAD    | loader owns RAM port, core stalled
  // ST_FLUSH   | download ended, draining FIFO before returning to core
  ldr_state_t    r_state;
  logic          r_dl_q;
  logic          r_gap;
  logic          r_wait;
  logic          r_busy;
  logic          r_overflow;
  logic [23:0]   r_words;

  entry_t        w_push_entry;
  entry_t        w_head;
  logic          w_active;
  logic          w_load;
  logic          w_push;
  logic          w_pop;
  logic          w_req;
  logic          w_full;
  logic          w_empty;
  logic          w_dl_rise;
  logic          w_core_done;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_next_count;

  generate
    if (AW > RAW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^ioctl_addr[AW-1:RAW];
    end
  endgenerate

  assign w_active    = (r_state != ST_IDLE);
  assign w_load      = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign w_dl_rise   = ioctl_download && !r_dl_q;
  assign w_core_done = !core.cyc || ram.ack;
  assign w_push      = w_active && ioctl_wr && !w_full;
  // One idle cycle after every ack before the next entry is presented.
  assign w_req       = w_load && !w_empty && !r_gap;
  assign w_pop       = w_req && ram.ack;
  assign w_next_count = w_count + CW'(w_push) - CW'(w_pop);

  assign w_push_entry.adr = RAW'(word_align(32'(ioctl_addr[RAW-1:0]), SW)) + BASE;
  assign w_push_entry.dat = ioctl_dout;
  assign w_push_entry.sel = ioctl_sel;

  ldr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    ram.stb  = core.stb;
    ram.cyc  = core.cyc;
    ram.we   = core.we;
    ram.sel  = core.sel;
    ram.adr  = RAW'(word_align(32'(core.adr), SW));
    ram.dat  = core.dat;
    core.ack = ram.ack;
    if (w_load) begin
      ram.stb  = w_req;
      ram.cyc  = w_req;
      ram.we   = w_req;
      ram.sel  = w_head.sel;
      ram.adr  = w_head.adr;
      ram.dat  = w_head.dat;
      core.ack = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dl_q     <= 1'b0;
      r_gap      <= 1'b0;
      r_wait     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_words    <= '0;
    end else begin
      r_dl_q <= ioctl_download;
      r_gap  <= w_pop;
      r_wait <= (w_next_count >= CW'(DEPTH - 1));
      if (w_pop) r_words <= r_words + 24'd1;
      if (w_active && ioctl_wr && w_full) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_dl_rise) begin
            r_state    <= ST_HANDOFF;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
            r_words    <= '0;
          end
        end
        ST_HANDOFF: begin
          if (w_core_done) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!ioctl_download) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_dl_rise) begin
            r_state <= ST_LOAD;
          end else if (w_empty) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ioctl_wait = r_wait;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign words      = r_words;

endmodule

// File: tb/tb_ioctl_wb_loader.sv
// Randomized bench for ioctl_wb_loader: a queue model of accepted words is
// matched against every RAM write, with a latency-programmable RAM responder.
module tb_ioctl_wb_loader;
  import archie_loader_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 25;
  localparam int RAW   = 24;
  localparam int DEPTH = 4;
  localparam int SW    = 4;
  localparam int BASE  = 'h100000;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic [SW-1:0] ioctl_sel;
  logic          ioctl_wait;
  logic          busy;
  logic          overflow;
  logic [23:0]   words;
  logic          man_ack;
  logic          rsp_ack;

  always #5 clk_sys = ~clk_sys;

  ioctl_wb_loader_if #(.DW(DW), .RAW(RAW)) core_bus ();
  ioctl_wb_loader_if #(.DW(DW), .RAW(RAW)) ram_bus ();

  assign ram_bus.ack = man_ack | rsp_ack;

  ioctl_wb_loader #(
    .DW(DW), .AW(AW), .RAW(RAW), .DEPTH(DEPTH), .BASE(24'(BASE))
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_sel      (ioctl_sel),
    .ioctl_wait     (ioctl_wait),
    .core           (core_bus),
    .ram            (ram_bus),
    .busy           (busy),
    .overflow       (overflow),
    .words          (words)
  );

  int          total = 0;
  int          bad   = 0;
  fifo_entry_t exp_q[$];
  fifo_entry_t cap;
  int          mocc   = 0;
  int          mwords = 0;
  int          wbase  = 0;
  logic        ldr_on = 1'b0;
  logic        rsp_en = 1'b0;
  int          rsp_lat = 1;
  int          lat_cnt = 0;
  bit          seen_wait = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model update on the rising edge, responder and checks on the falling edge.
  task automatic tick();
    fifo_entry_t e;
    @(posedge clk_sys);
    if (reset) begin
      exp_q.delete();
      mocc = 0;
    end else begin
      if (ldr_on && ioctl_wr && mocc < DEPTH) begin
        e.adr = 24'((((int'(ioctl_addr) % (1 << RAW)) / SW) * SW + BASE) % (1 << RAW));
        e.dat = ioctl_dout;
        e.sel = ioctl_sel;
        exp_q.push_back(e);
        mocc++;
      end
      if (rsp_ack) begin
        expect_eq("ram_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          expect_eq("ram_adr", 32'(cap.adr), 32'(e.adr));
          expect_eq("ram_dat", cap.dat, e.dat);
          expect_eq("ram_sel", 32'(cap.sel), 32'(e.sel));
        end
        mocc--;
        mwords++;
      end
    end
    @(negedge clk_sys);
    if (rsp_ack) begin
      rsp_ack = 1'b0;
      lat_cnt = 0;
    end else if (!rsp_en) begin
      lat_cnt = 0;
    end else if (ram_bus.stb && ram_bus.cyc) begin
      lat_cnt++;
      if (lat_cnt >= rsp_lat) begin
        cap.adr = ram_bus.adr;
        cap.dat = ram_bus.dat;
        cap.sel = ram_bus.sel;
        expect_eq("ram_we", 32'(ram_bus.we), 1);
        rsp_ack = 1'b1;
        lat_cnt = 0;
      end
    end
    expect_eq("ioctl_wait", 32'(ioctl_wait), 32'(mocc >= DEPTH - 1));
    if (ioctl_wait) seen_wait = 1'b1;
  endtask

  task automatic hps_write(input bit honour);
    int guard;
    guard = 0;
    ioctl_wr = 1'b0;
    while (honour && ioctl_wait && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) expect_eq("wait_timeout", 32'(ioctl_wait), 0);
    ioctl_addr = AW'($urandom);
    ioctl_dout = $urandom;
    ioctl_sel  = SW'($urandom);
    ioctl_wr   = 1'b1;
    tick();
  endtask

  task automatic drain();
    int g;
    g = 0;
    ioctl_wr = 1'b0;
    while (mocc > 0 && g < 500) begin
      tick();
      g++;
    end
    if (mocc > 0) expect_eq("drain_timeout", 32'(ram_bus.stb), 0);
    tick();
    tick();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 500) begin
      tick();
      g++;
    end
    expect_eq("idle_reached", 32'(busy), 0);
  endtask

  task automatic core_idle();
    core_bus.stb = 1'b0;
    core_bus.cyc = 1'b0;
    core_bus.we  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_sel = '0;
    man_ack = 1'b0;
    rsp_ack = 1'b0;
    core_idle();
    core_bus.sel = '0;
    core_bus.adr = '0;
    core_bus.dat = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    expect_eq("rst_busy", 32'(busy), 0);
    expect_eq("rst_wait", 32'(ioctl_wait), 0);
    expect_eq("rst_ovf", 32'(overflow), 0);
    expect_eq("rst_words", 32'(words), 0);
    expect_eq("rst_ram_stb", 32'(ram_bus.stb), 0);

    // Idle passthrough
    core_bus.cyc = 1'b1; core_bus.stb = 1'b1; core_bus.we = 1'b0;
    core_bus.adr = 24'h000104; core_bus.sel = 4'hF; core_bus.dat = $urandom;
    #1;
    expect_eq("pt_stb", 32'(ram_bus.stb), 1);
    expect_eq("pt_adr", 32'(ram_bus.adr), 32'h104);
    expect_eq("pt_dat", ram_bus.dat, core_bus.dat);
    expect_eq("pt_busy", 32'(busy), 0);
    expect_eq("pt_ack_lo", 32'(core_bus.ack), 0);
    man_ack = 1'b1;
    #1;
    expect_eq("pt_ack", 32'(core_bus.ack), 1);
    tick();
    man_ack = 1'b0;
    core_bus.adr = 24'h000107; core_bus.we = 1'b1; core_bus.sel = 4'h8;
    #1;
    expect_eq("pt_align", 32'(ram_bus.adr), 32'h104);
    expect_eq("pt_we", 32'(ram_bus.we), 1);
    expect_eq("pt_sel", 32'(ram_bus.sel), 32'h8);
    tick();

    // Handoff with a core cycle waiting on ack
    core_bus.we = 1'b0;
    ioctl_download = 1'b1;
    wbase = mwords;
    tick();
    tick();
    expect_eq("ho_busy", 32'(busy), 1);
    expect_eq("ho_pt_stb", 32'(ram_bus.stb), 1);
    man_ack = 1'b1;
    #1;
    expect_eq("ho_core_ack", 32'(core_bus.ack), 1);
    tick();
    man_ack = 1'b0;
    #1;
    expect_eq("iso_ram_stb", 32'(ram_bus.stb), 0);
    man_ack = 1'b1;
    #1;
    expect_eq("iso_core_ack", 32'(core_bus.ack), 0);
    tick();
    man_ack = 1'b0;
    core_idle();
    tick();

    // Burst of 8 with ack latency 5, HPS honouring wait
    ldr_on = 1'b1;
    rsp_en = 1'b1;
    rsp_lat = 5;
    seen_wait = 1'b0;
    for (int i = 0; i < 8; i++) hps_write(1'b1);
    drain();
    expect_eq("burst_seen_wait", 32'(seen_wait), 1);
    expect_eq("burst_words", 32'(words), 32'(mwords - wbase));
    expect_eq("burst_words8", 32'(mwords - wbase), 8);
    expect_eq("burst_ovf", 32'(overflow), 0);
    expect_eq("burst_core_ack", 32'(core_bus.ack), 0);

    // Overflow: wait ignored, ack withheld
    rsp_en = 1'b0;
    for (int i = 0; i < 6; i++) hps_write(1'b0);
    ioctl_wr = 1'b0;
    tick();
    expect_eq("ovf_flag", 32'(overflow), 1);
    rsp_en = 1'b1;
    rsp_lat = 2;
    drain();
    expect_eq("ovf_words", 32'(words), 32'(mwords - wbase));
    expect_eq("ovf_words12", 32'(mwords - wbase), 12);

    // Flush with three entries queued
    rsp_en = 1'b0;
    for (int i = 0; i < 3; i++) hps_write(1'b1);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    expect_eq("fl_busy", 32'(busy), 1);
    rsp_en = 1'b1;
    wait_idle();
    drain();
    expect_eq("fl_words", 32'(words), 32'(mwords - wbase));
    expect_eq("fl_words15", 32'(mwords - wbase), 15);
    expect_eq("fl_ovf_sticky", 32'(overflow), 1);
    rsp_en = 1'b0;
    core_bus.cyc = 1'b1; core_bus.stb = 1'b1; core_bus.adr = 24'h000ABE;
    #1;
    expect_eq("fl_pt_stb", 32'(ram_bus.stb), 1);
    expect_eq("fl_pt_adr", 32'(ram_bus.adr), 32'hABC);
    tick();
    core_idle();
    tick();

    // Randomized download
    ioctl_download = 1'b1;
    wbase = mwords;
    repeat (3) tick();
    expect_eq("rnd_words_clr", 32'(words), 0);
    expect_eq("rnd_ovf_clr", 32'(overflow), 0);
    expect_eq("rnd_busy", 32'(busy), 1);
    rsp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rsp_lat = int'($urandom_range(1, 4));
      hps_write(1'b1);
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    expect_eq("rnd_words", 32'(words), 32'(mwords - wbase));
    expect_eq("rnd_ovf", 32'(overflow), 0);
    ioctl_download = 1'b0;
    wait_idle();

    // Reset with an outstanding request and two entries held
    ioctl_download = 1'b1;
    repeat (3) tick();
    rsp_en = 1'b0;
    hps_write(1'b1);
    hps_write(1'b1);
    ioctl_wr = 1'b0;
    tick();
    tick();
    expect_eq("rm_stb_before", 32'(ram_bus.stb), 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    expect_eq("rm_stb", 32'(ram_bus.stb), 0);
    expect_eq("rm_words", 32'(words), 0);
    expect_eq("rm_busy", 32'(busy), 0);
    expect_eq("rm_wait", 32'(ioctl_wait), 0);
    reset = 1'b0;
    tick();
    ioctl_download = 1'b1;
    wbase = mwords;
    repeat (3) tick();
    rsp_en = 1'b1;
    rsp_lat = 1;
    hps_write(1'b1);
    drain();
    tick();
    expect_eq("rm_fifo_empty_words", 32'(words), 1);
    ioctl_download = 1'b0;
    wait_idle();
    rsp_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
